irq_ctl: RTL and testbench

IRQ_CTL -- requirements
Module: irq_ctl

---
 rtl/irq_ctl_pkg.sv | 30 +++
 rtl/irq_ctl_if.sv | 13 +
 rtl/irq_sync.sv | 30 +++
 rtl/irq_ctl.sv | 105 ++++++++++
 tb/tb_irq_ctl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctl_pkg.sv
// Shared definitions for the interrupt controller: register map, CLAIM
// word layout and the supported source count.
package irq_ctl_pkg;

  localparam int NSRC_MAX        = 31;
  localparam int REG_SEL_LSB     = 2;
  localparam int CLAIM_VALID_BIT = 31;
  localparam int CLAIM_ID_W      = 5;

  localparam logic [3:0] OFS_PENDING = 4'h0;
  localparam logic [3:0] OFS_ENABLE  = 4'h4;
  localparam logic [3:0] OFS_MODE    = 4'h8;
  localparam logic [3:0] OFS_CLAIM   = 4'hC;

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_ENABLE  = 2'd1,
    REG_MODE    = 2'd2,
    REG_CLAIM   = 2'd3
  } reg_sel_e;

  // Pack a claim result into the 32-bit read word.
  function automatic logic [31:0] claim_word(input logic vld,
                                             input logic [CLAIM_ID_W-1:0] id);
    claim_word                   = '0;
    claim_word[CLAIM_VALID_BIT]  = vld;
    claim_word[CLAIM_ID_W-1:0]   = id;
  endfunction

endpackage

// File: rtl/irq_ctl_if.sv
// Register bus between the core side (master) and the controller (slave).
interface irq_ctl_if;
  logic [3:0]  bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (output bus_addr, output bus_wr, output bus_rd,
                  output bus_wdata, input bus_rdata);
  modport slave  (input bus_addr, input bus_wr, input bus_rd,
                  input bus_wdata, output bus_rdata);
endinterface

// File: rtl/irq_sync.sv
// Two-flop synchronizer plus a history flop for edge detection.
module irq_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] s2_o,
  output logic [W-1:0] prev_o
);

  logic [W-1:0] s1_q, s2_q, prev_q;

  // Synchronizer chain; prev holds the previous synchronized value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign s2_o   = s2_q;
  assign prev_o = prev_q;

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: per-source edge/level pending, enable mask,
// lowest-index-first claim and a registered irq to the core.
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  irq_ctl_if.slave        bus,
  output logic            irq
);

  logic [NSRC-1:0] s2, prev;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] enable_q, mode_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            irq_q;

  logic                  claim_vld;
  logic [CLAIM_ID_W-1:0] claim_id;
  logic [NSRC-1:0]       claim_oh;
  logic [NSRC-1:0]       clr;
  logic [NSRC-1:0]       edge_next;

  reg_sel_e sel;
  logic     wr_pend, wr_en, wr_mode, rd_claim;
  logic     unused_bus;

  irq_sync #(.W(NSRC)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (src),
    .s2_o   (s2),
    .prev_o (prev)
  );

  assign sel      = reg_sel_e'(bus.bus_addr[REG_SEL_LSB+1:REG_SEL_LSB]);
  assign wr_pend  = bus.bus_wr && (sel == REG_PENDING);
  assign wr_en    = bus.bus_wr && (sel == REG_ENABLE);
  assign wr_mode  = bus.bus_wr && (sel == REG_MODE);
  assign rd_claim = bus.bus_rd && (sel == REG_CLAIM);

  // Byte-lane bits and data bits above NSRC carry no meaning here.
  assign unused_bus = ^{bus.bus_addr[1:0], bus.bus_wdata};

  // Lowest active index wins: scan downward so the last hit is the smallest.
  always_comb begin
    claim_vld = 1'b0;
    claim_id  = '0;
    claim_oh  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending_q[i] && enable_q[i]) begin
        claim_vld   = 1'b1;
        claim_id    = CLAIM_ID_W'(i);
        claim_oh    = '0;
        claim_oh[i] = 1'b1;
      end
    end
  end

  // Edge bits: new edges set (and beat any clear), W1C/claim clear.
  // Level bits simply track the synchronized input.
  always_comb begin
    clr = '0;
    if (wr_pend)  clr = clr | bus.bus_wdata[NSRC-1:0];
    if (rd_claim) clr = clr | claim_oh;
    edge_next = (s2 & ~prev) | (pending_q & ~clr);
    pending_d = (mode_q & edge_next) | (~mode_q & s2);
  end

  // Read mux; only captured on a read strobe so the value holds afterwards.
  always_comb begin
    rdata_d = '0;
    case (sel)
      REG_PENDING: rdata_d = 32'(pending_q);
      REG_ENABLE:  rdata_d = 32'(enable_q);
      REG_MODE:    rdata_d = 32'(mode_q);
      REG_CLAIM:   rdata_d = claim_word(claim_vld, claim_id);
      default:     rdata_d = '0;
    endcase
  end

  // Register state, read data and the irq output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (wr_en)      enable_q <= bus.bus_wdata[NSRC-1:0];
      if (wr_mode)    mode_q   <= bus.bus_wdata[NSRC-1:0];
      if (bus.bus_rd) rdata_q  <= rdata_d;
      irq_q <= |(pending_q & enable_q);
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: reads are checked by a scoreboard monitor,
// irq and reset state are checked inline.
module tb_irq_ctl;
  import irq_ctl_pkg::*;

  localparam int NSRC = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NSRC-1:0] src = '0;
  logic            irq;

  irq_ctl_if bus_if ();

  irq_ctl #(.NSRC(NSRC)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .bus   (bus_if),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic rd_d  = 1'b0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_d <= bus_if.bus_rd;
  end

  // Monitor: one cycle after a read strobe, bus_rdata must match the queue head.
  always @(negedge clk) begin
    if (rd_d) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got=%h with empty scoreboard", bus_if.bus_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus_if.bus_rdata !== e.val) begin
          bad++;
          $display("FAIL %s: got=%h want=%h", e.name, bus_if.bus_rdata, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, want);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = data;
    bus_if.bus_wr    = 1'b1;
    tick();
    bus_if.bus_wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr, input logic [31:0] want, input string name);
    exp_t e;
    e.val  = want;
    e.name = name;
    exp_q.push_back(e);
    bus_if.bus_addr = addr;
    bus_if.bus_rd   = 1'b1;
    tick();
    bus_if.bus_rd   = 1'b0;
  endtask

  initial begin
    int claims;
    int start;
    bus_if.bus_addr  = '0;
    bus_if.bus_wr    = 1'b0;
    bus_if.bus_rd    = 1'b0;
    bus_if.bus_wdata = '0;

    // Reset state
    ticks(3);
    reset = 1'b0;
    tick();
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", bus_if.bus_rdata, 32'h0);
    bus_read(OFS_PENDING, 32'h0, "rst_pending");
    bus_read(OFS_ENABLE,  32'h0, "rst_enable");
    bus_read(OFS_MODE,    32'h0, "rst_mode");

    // Edge source 0: 4-cycle latency, claim, irq drops one cycle later
    bus_write(OFS_MODE,   32'hFF);
    bus_write(OFS_ENABLE, 32'h01);
    src[0] = 1'b1;
    ticks(3);
    chk("edge_irq_early", 32'(irq), 32'h0);
    src[0] = 1'b0;
    tick();
    chk("edge_irq_4th", 32'(irq), 32'h1);
    bus_read(OFS_PENDING, 32'h01, "edge_pending");
    bus_read(OFS_CLAIM,   32'h8000_0000, "edge_claim0");
    chk("edge_irq_claim_cycle", 32'(irq), 32'h1);
    bus_read(OFS_PENDING, 32'h00, "edge_pending_after");
    chk("edge_irq_after", 32'(irq), 32'h0);

    // Two simultaneous edge sources claimed lowest-first
    bus_write(OFS_ENABLE, 32'h24);
    bus_write(OFS_MODE,   32'h24);
    src[5] = 1'b1;
    src[2] = 1'b1;
    ticks(4);
    bus_read(OFS_CLAIM, 32'h8000_0002, "prio_claim2");
    bus_read(OFS_CLAIM, 32'h8000_0005, "prio_claim5");
    bus_read(OFS_CLAIM, 32'h0000_0000, "prio_claim_none");
    src = '0;
    ticks(4);

    // Level source 3 ignores claim and W1C
    bus_write(OFS_MODE,   32'h00);
    bus_write(OFS_ENABLE, 32'h08);
    src[3] = 1'b1;
    ticks(4);
    chk("lvl_irq_on", 32'(irq), 32'h1);
    bus_read(OFS_PENDING, 32'h08, "lvl_pending");
    bus_read(OFS_CLAIM,   32'h8000_0003, "lvl_claim");
    bus_write(OFS_PENDING, 32'h08);
    bus_read(OFS_PENDING, 32'h08, "lvl_pending_w1c");
    chk("lvl_irq_hold", 32'(irq), 32'h1);
    src[3] = 1'b0;
    ticks(3);
    chk("lvl_irq_3", 32'(irq), 32'h1);
    tick();
    chk("lvl_irq_off", 32'(irq), 32'h0);

    // Edge set coinciding with W1C: set wins; a later W1C clears
    bus_write(OFS_ENABLE, 32'h00);
    bus_write(OFS_MODE,   32'h02);
    src[1] = 1'b1;
    ticks(2);
    bus_write(OFS_PENDING, 32'h02);
    bus_read(OFS_PENDING, 32'h02, "w1c_race_set_wins");
    bus_write(OFS_PENDING, 32'h02);
    bus_read(OFS_PENDING, 32'h00, "w1c_clear");
    src[1] = 1'b0;
    ticks(3);

    // Out-of-range bits, ignored address LSBs, writes to CLAIM
    bus_write(OFS_ENABLE, 32'hFFFF_FFFF);
    bus_read(4'h5, 32'h0000_00FF, "enable_masked");
    bus_write(OFS_CLAIM, 32'h0000_0000);
    bus_read(OFS_ENABLE, 32'h0000_00FF, "claim_write_ignored");
    bus_write(OFS_ENABLE, 32'h00);
    chk("rdata_holds", bus_if.bus_rdata, 32'h0000_00FF);

    // Reset mid-operation with a pending edge and irq high
    bus_write(OFS_MODE,   32'h10);
    bus_write(OFS_ENABLE, 32'h10);
    src[4] = 1'b1;
    ticks(4);
    chk("mid_irq_before", 32'(irq), 32'h1);
    src[4] = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_irq_async", 32'(irq), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    bus_read(OFS_PENDING, 32'h0, "mid_pending");
    bus_read(OFS_ENABLE,  32'h0, "mid_enable");
    bus_read(OFS_MODE,    32'h0, "mid_mode");
    ticks(4);
    chk("mid_irq_quiet", 32'(irq), 32'h0);

    // Handler loop: pulses at 200 and 400, each claimed exactly once
    bus_write(OFS_MODE,   32'h01);
    bus_write(OFS_ENABLE, 32'h01);
    claims = 0;
    start  = cyc;
    while (cyc - start < 600) begin
      src[0] = ((cyc - start) >= 200 && (cyc - start) < 203) ||
               ((cyc - start) >= 400 && (cyc - start) < 403);
      if (irq) begin
        bus_read(OFS_CLAIM, 32'h8000_0000, "handler_claim");
        claims++;
        tick();
      end else begin
        tick();
      end
    end
    src = '0;
    chk("handler_claims", 32'(claims), 32'd2);
    chk("handler_irq_idle", 32'(irq), 32'h0);

    ticks(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
